// File: rtl/clk_div_ctrl_if.sv
// Ratio-request handshake between a requester and the divider sequencing controller.
interface clk_div_ctrl_if #(parameter int SEL_W = 3);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [SEL_W-1:0] cfg_sel;

    modport master (output cfg_valid, output cfg_sel, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_sel, output cfg_ready);
endinterface

// File: rtl/clk_div_ctrl.sv
// Glitch-safe ratio change sequencer for the HBWIF divide-by-N slices:
// gate, drain, reset divider with new select, settle, ungate.
//
// state  | meaning
// IDLE   | clock running, requests accepted
// DRAIN  | clock gated, waiting for downstream to empty
// RST    | divider held in reset, new select applied
// SETTLE | reset released, clock still gated
module clk_div_ctrl #(
    parameter int SEL_W         = 3,
    parameter int NUM_SEL       = 5,
    parameter int DEFAULT_SEL   = 0,
    parameter int DRAIN_CYCLES  = 8,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    clk_div_ctrl_if.slave    cfg,
    input  logic             resync,
    output logic [SEL_W-1:0] div_sel,
    output logic             div_rst,
    output logic             clk_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_RST    = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W:0]   NUM_SEL_V   = (SEL_W + 1)'(NUM_SEL);
    localparam logic [SEL_W-1:0] DEF_SEL_V   = SEL_W'(DEFAULT_SEL);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] pend_sel;
    logic             sel_illegal;

    assign busy          = (state != ST_IDLE);
    assign cfg.cfg_ready = (state == ST_IDLE) && !resync;
    assign sel_illegal   = ({1'b0, cfg.cfg_sel} >= NUM_SEL_V);

    // Reset lands in RST so power-up runs RST then SETTLE without a DRAIN phase.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RST;
            cnt      <= '0;
            pend_sel <= DEF_SEL_V;
            div_sel  <= DEF_SEL_V;
            div_rst  <= 1'b1;
            clk_en   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (resync) begin
                state   <= ST_DRAIN;
                cnt     <= '0;
                div_rst <= 1'b0;
                clk_en  <= 1'b0;
                if (state == ST_IDLE) begin
                    pend_sel <= div_sel;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cfg.cfg_valid) begin
                            if (sel_illegal) begin
                                err <= 1'b1;
                            end else if (cfg.cfg_sel == div_sel) begin
                                done <= 1'b1;
                            end else begin
                                pend_sel <= cfg.cfg_sel;
                                state    <= ST_DRAIN;
                                cnt      <= '0;
                                clk_en   <= 1'b0;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (cnt == DRAIN_LAST) begin
                            state   <= ST_RST;
                            cnt     <= '0;
                            div_rst <= 1'b1;
                            div_sel <= pend_sel;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_RST: begin
                        if (cnt == RST_LAST) begin
                            state   <= ST_SETTLE;
                            cnt     <= '0;
                            div_rst <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        if (cnt == SETTLE_LAST) begin
                            state  <= ST_IDLE;
                            cnt    <= '0;
                            clk_en <= 1'b1;
                            done   <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: timeline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_clk_div_ctrl;
    localparam int SEL_W = 3, NUM_SEL = 5, DEF = 0;
    localparam int D = 8, R = 4, S = 16, CNT_W = 8;
    localparam int LAST = D + R + S;

    logic             clk_in = 1'b0;
    logic             rst_n  = 1'b0;
    logic             resync = 1'b0;
    logic [SEL_W-1:0] div_sel;
    logic             div_rst, clk_en, busy, done, err;

    clk_div_ctrl_if #(.SEL_W(SEL_W)) cfg ();

    clk_div_ctrl #(
        .SEL_W(SEL_W), .NUM_SEL(NUM_SEL), .DEFAULT_SEL(DEF),
        .DRAIN_CYCLES(D), .RST_CYCLES(R), .SETTLE_CYCLES(S), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .cfg(cfg), .resync(resync),
        .div_sel(div_sel), .div_rst(div_rst), .clk_en(clk_en),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a sequence is a timeline anchored at the edge that started it.
    // Offset 1..D drain, D+1..D+R reset, then settle, done at LAST+1.
    int n;
    bit m_active;
    int m_start, m_pend, m_sel_base, m_done_n, m_err_n;
    int ph_e, off_e, ph_c;

    function automatic int m_phase();
        int off;
        off = n - m_start;
        if (!m_active || off > LAST) return 0;
        if (off <= D) return 1;
        if (off <= D + R) return 2;
        return 3;
    endfunction

    function automatic int m_div_sel();
        if (m_active && (n - m_start) >= D + 1) return m_pend;
        return m_sel_base;
    endfunction

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; m_active = 1'b1; m_start = -(D + 1);
            m_pend = DEF; m_sel_base = DEF; m_done_n = -1; m_err_n = -1;
        end else begin
            ph_e  = m_phase();
            off_e = n - m_start;
            if (m_active && off_e > LAST) begin
                m_active = 1'b0;
                m_sel_base = m_pend;
            end
            if (resync) begin
                if (ph_e == 0) m_pend = m_sel_base;
                else if (off_e >= D + 1) m_sel_base = m_pend;
                m_active = 1'b1;
                m_start = n;
            end else if (ph_e == 0) begin
                if (cfg.cfg_valid) begin
                    if (int'(cfg.cfg_sel) >= NUM_SEL) m_err_n = n + 1;
                    else if (int'(cfg.cfg_sel) == m_sel_base) m_done_n = n + 1;
                    else begin
                        m_pend = int'(cfg.cfg_sel);
                        m_active = 1'b1;
                        m_start = n;
                    end
                end
            end else if (off_e == LAST) begin
                m_done_n = n + 1;
            end
            n = n + 1;
        end
    end

    always @(negedge clk_in) begin
        ph_c = m_phase();
        chk("busy",      busy,          ph_c != 0);
        chk("clk_en",    clk_en,        ph_c == 0);
        chk("div_rst",   div_rst,       ph_c == 2);
        chk("div_sel",   div_sel,       m_div_sel());
        chk("done",      done,          n == m_done_n);
        chk("err",       err,           n == m_err_n);
        chk("cfg_ready", cfg.cfg_ready, (ph_c == 0) && !resync);
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk_in);
        #1;
    endtask

    task automatic wait_done(input int max, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick(1);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, ok, 1'b1);
    endtask

    int done_cnt;

    initial begin
        cfg.cfg_valid = 1'b0;
        cfg.cfg_sel   = '0;

        // Power-on
        tick(3);
        chk("por_div_rst", div_rst, 1); chk("por_clk_en", clk_en, 0);
        chk("por_busy", busy, 1);       chk("por_ready", cfg.cfg_ready, 0);
        rst_n = 1'b1;
        tick(19);
        chk("por_pre_done", done, 0); chk("por_pre_en", clk_en, 0);
        tick(1);
        chk("por_done", done, 1); chk("por_en", clk_en, 1);
        chk("por_sel", div_sel, 0); chk("por_ready1", cfg.cfg_ready, 1);

        // Legal change 0 -> 3
        cfg.cfg_valid = 1'b1; cfg.cfg_sel = 3'd3;
        tick(1);
        cfg.cfg_valid = 1'b0;
        chk("chg_c1_en", clk_en, 0); chk("chg_c1_busy", busy, 1);
        tick(7);  chk("chg_c8_rst", div_rst, 0);
        tick(1);  chk("chg_c9_rst", div_rst, 1); chk("chg_c9_sel", div_sel, 3);
        tick(3);  chk("chg_c12_rst", div_rst, 1);
        tick(1);  chk("chg_c13_rst", div_rst, 0);
        tick(15); chk("chg_c28_busy", busy, 1); chk("chg_c28_en", clk_en, 0);
        tick(1);  chk("chg_c29_done", done, 1); chk("chg_c29_busy", busy, 0);
        chk("chg_c29_en", clk_en, 1);
        tick(1);  chk("chg_c30_done", done, 0);

        // Illegal select
        cfg.cfg_valid = 1'b1; cfg.cfg_sel = 3'd6;
        tick(1);
        cfg.cfg_valid = 1'b0;
        chk("ill_err", err, 1); chk("ill_sel", div_sel, 3);
        chk("ill_en", clk_en, 1); chk("ill_done", done, 0);
        tick(1);  chk("ill_err_clr", err, 0);

        // Same ratio
        cfg.cfg_valid = 1'b1; cfg.cfg_sel = 3'd3;
        tick(1);
        cfg.cfg_valid = 1'b0;
        chk("same_done", done, 1); chk("same_en", clk_en, 1); chk("same_err", err, 0);

        // Resync during RST of a change to 2
        tick(1);
        cfg.cfg_valid = 1'b1; cfg.cfg_sel = 3'd2;
        tick(1);
        cfg.cfg_valid = 1'b0;
        tick(9);
        resync = 1'b1;
        tick(1);
        resync = 1'b0;
        chk("rsy_rst", div_rst, 0); chk("rsy_en", clk_en, 0); chk("rsy_sel", div_sel, 2);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (done === 1'b1) done_cnt++;
        end
        chk("rsy_done_cnt", done_cnt, 1); chk("rsy_final_sel", div_sel, 2);

        // Backpressure: second request held while the first runs
        cfg.cfg_valid = 1'b1; cfg.cfg_sel = 3'd4;
        tick(1);
        cfg.cfg_sel = 3'd1;
        wait_done(40, "bp_first_timeout");
        chk("bp_ready_idle", cfg.cfg_ready, 1); chk("bp_sel4", div_sel, 4);
        tick(1);
        cfg.cfg_valid = 1'b0;
        chk("bp_second_busy", busy, 1);
        wait_done(40, "bp_second_timeout");
        chk("bp_sel1", div_sel, 1);

        // Async reset mid-sequence
        tick(1);
        cfg.cfg_valid = 1'b1; cfg.cfg_sel = 3'd3;
        tick(1);
        cfg.cfg_valid = 1'b0;
        tick(14);
        rst_n = 1'b0;
        #1;
        chk("ar_rst", div_rst, 1); chk("ar_en", clk_en, 0); chk("ar_busy", busy, 1);
        chk("ar_sel", div_sel, DEF); chk("ar_done", done, 0); chk("ar_ready", cfg.cfg_ready, 0);
        tick(2);
        rst_n = 1'b1;
        wait_done(40, "ar_por_timeout");
        chk("ar_final_sel", div_sel, DEF);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cfg.cfg_valid = ($urandom_range(0, 3) == 0);
            cfg.cfg_sel   = SEL_W'($urandom_range(0, 7));
            resync        = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
            tick(1);
        end
        cfg.cfg_valid = 1'b0;
        resync = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Sequencing controller for the HBWIF programmable clock dividers (divide-by-N slices selected by an index).
- Accepts a divide-ratio request over a valid/ready handshake and performs a glitch-safe ratio change: gate the downstream clock, drain, reset the divider, apply the new select, settle, then ungate.
- Runs on the divider's input (reference) clock.
- Drives only the control pins (select, reset, clock-gate enable). It never touches the divided clock itself.

Parameters:
- SEL_W, 3, width of ratio-select index.
- NUM_SEL, 5, number of legal select codes (0..NUM_SEL-1). Codes >= NUM_SEL are illegal.
- DEFAULT_SEL, 0, select applied by the power-on sequence. Must be < NUM_SEL.
- DRAIN_CYCLES, 8, cycles clk_en is held low before divider reset. Must be >= 1.
- RST_CYCLES, 4, cycles div_rst is held high. Must be >= 1.
- SETTLE_CYCLES, 16, cycles after reset release before ungating. Must be >= 1.
- CNT_W, 8, phase counter width. Must hold max(DRAIN,RST,SETTLE)-1.

Ports:
- clk_in  in  1  reference clock; all logic is posedge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  ratio request valid.
- cfg_ready  out  1  controller can accept a request.
- cfg_sel  in  SEL_W  requested ratio index.
- resync  in  1  level request to re-run the sequence with the current/pending select.
- div_sel  out  SEL_W  select to divider, registered.
- div_rst  out  1  synchronous reset to divider, registered.
- clk_en  out  1  downstream clock-gate enable, registered.
- busy  out  1  sequence in progress (state != IDLE).
- done  out  1  one-cycle pulse when a sequence completes or a same-ratio request is accepted.
- err  out  1  one-cycle pulse on acceptance of an illegal cfg_sel.

Behaviour:
Interface (already decided):
- One clock, clk_in.
- Reset is asynchronous and active-low: rst_n.

FSM states: IDLE, DRAIN, RST, SETTLE. One phase counter (CNT_W) and one pending-select register (SEL_W).

Output reset values (rst_n low):
- state=RST, cnt=0, pend_sel=DEFAULT_SEL, div_sel=DEFAULT_SEL.
- div_rst=1, clk_en=0, busy=1, cfg_ready=0, done=0, err=0.
- After rst_n deasserts, the controller completes RST then SETTLE, i.e. a power-on sequence without DRAIN.

Handshake:
- cfg_ready = (state==IDLE) && !resync.
- Transfer occurs when cfg_valid && cfg_ready at a rising edge.
- cfg_sel is sampled only on transfer.

On transfer:
- cfg_sel >= NUM_SEL: err=1 for the next cycle; state stays IDLE; div_sel unchanged; clk_en stays 1.
- cfg_sel == div_sel: done=1 for the next cycle; no sequence; outputs otherwise unchanged.
- Otherwise: pend_sel<=cfg_sel; go to DRAIN.

States:
- DRAIN: clk_en=0, div_rst=0. Lasts exactly DRAIN_CYCLES cycles.
- RST: div_rst=1, clk_en=0. div_sel<=pend_sel on entry (the same edge that sets div_rst). Lasts RST_CYCLES cycles.
- SETTLE: div_rst=0, clk_en=0. Lasts SETTLE_CYCLES cycles.
- IDLE on exit from SETTLE: clk_en=1 and done=1 in the first IDLE cycle.
- div_sel changes only while div_rst=1.

Latency:
- Transfer at edge 0 gives the following, where D/R/S = DRAIN/RST/SETTLE_CYCLES:
  - DRAIN in cycles 1..D.
  - RST in cycles D+1..D+R.
  - SETTLE in cycles D+R+1..D+R+S.
  - IDLE with done and clk_en high at cycle D+R+S+1.
- With defaults, done is at cycle 29.

resync:
- Sampled each edge and has priority over cfg handshake.
- In IDLE: go to DRAIN with pend_sel=div_sel.
- In DRAIN/RST/SETTLE: restart at DRAIN with cnt=0 and pend_sel retained. clk_en stays 0; div_rst goes 0.
- Held high: the controller stays in DRAIN (cnt held at 0).

Other rules:
- done and err never assert together.
- done is never asserted when err fires or during resync restarts.
- Asynchronous reset mid-sequence: all outputs go to reset values immediately; the pending request is lost.
- Counter compares against PARAM-1; no wrap beyond the terminal value.

Test Plan:
- Power-on: rst_n low 3 cycles then high, defaults → div_rst=1 for 4 cycles after release, then 16 SETTLE cycles, then clk_en=1, done pulse, div_sel=0, cfg_ready=1.
- Legal change: from IDLE sel=0, send cfg_sel=3 → clk_en=0 at cycle 1, div_rst=1 with div_sel=3 at cycles 9-12, clk_en=1 with done at cycle 29, busy low from cycle 29.
- Illegal/same ratio: cfg_sel=6 → err pulse next cycle, div_sel and clk_en unchanged. cfg_sel equal to current → done pulse next cycle, clk_en never drops.
- Resync mid-RST: during a change to sel=2, pulse resync in cycle 10 → div_rst drops, DRAIN restarts (8 cycles), div_sel=2 at completion, single done pulse.
- Backpressure: hold cfg_valid with sel=1 during a busy sequence → cfg_ready=0 throughout, request accepted in the first IDLE cycle, then the second sequence runs.
- Async reset at cycle 15 of a sequence → outputs immediately take reset values; the power-on sequence then completes with div_sel=DEFAULT_SEL.
